// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the Memory stage and the data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        mem_stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  mem_stall, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output mem_stall, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with WAIT_CYCLES wait states per access and a one-cycle response.
// The array has no reset; INIT_ZERO only records the intended simulation fill policy.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int INIT_ZERO   = 1
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (INIT_ZERO != 0 && INIT_ZERO != 1) begin : g_bad_init
        $error("INIT_ZERO must be 0 or 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        eff_write;
    logic [31:0] eff_addr;
    logic        eff_err;
    logic [IDX_W-1:0] eff_idx;
    logic        enter_resp;
    logic [31:0] rdata_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the response is formed from the live request, otherwise from the latched one.
    always_comb begin
        eff_write  = accept ? bus.req_write : write_q;
        eff_addr   = accept ? bus.req_addr  : addr_q;
        eff_err    = (eff_addr[1:0] != 2'b00) ||
                     ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
        eff_idx    = eff_addr[IDX_W+1:2];
        enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);
        rdata_nxt  = '0;
        if (enter_resp && !eff_write && !eff_err) begin
            rdata_nxt = mem[eff_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                be_q    <= bus.req_be;
                wdata_q <= bus.req_wdata;
            end
            rsp_valid_q <= enter_resp;
            rsp_rdata_q <= rdata_nxt;
            rsp_err_q   <= enter_resp && eff_err;
        end
    end

    // Reset forces state to IDLE asynchronously, so an aborted store never reaches this write.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && write_q && !rsp_err_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q[IDX_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_stall = ((state == ST_IDLE) && bus.req_valid) || (state == ST_WAIT);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with two wait-state settings (2 and 0).
module tb_data_mem_responder;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .INIT_ZERO(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .INIT_ZERO(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the 2-wait-state instance; req_addr is switched to addr_late once accepted.
    task automatic access2(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic [31:0] addr_late);
        @(posedge clk); #1;
        bus2.req_valid = 1'b1; bus2.req_write = wr; bus2.req_addr = addr;
        bus2.req_be = be; bus2.req_wdata = wd;
        @(negedge clk);
        chk({tag, " c1 stall"}, 32'(bus2.mem_stall), 32'd1);
        chk({tag, " c1 valid"}, 32'(bus2.rsp_valid), 32'd0);
        chk({tag, " c1 busy"},  32'(bus2.busy),      32'd0);
        @(posedge clk); #1;
        bus2.req_valid = 1'b0; bus2.req_write = ~wr; bus2.req_addr = addr_late;
        bus2.req_wdata = ~wd; bus2.req_be = ~be;
        @(negedge clk);
        chk({tag, " c2 stall"}, 32'(bus2.mem_stall), 32'd1);
        chk({tag, " c2 busy"},  32'(bus2.busy),      32'd1);
        chk({tag, " c2 valid"}, 32'(bus2.rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " c3 stall"}, 32'(bus2.mem_stall), 32'd1);
        chk({tag, " c3 valid"}, 32'(bus2.rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " c4 valid"}, 32'(bus2.rsp_valid), 32'd1);
        chk({tag, " c4 stall"}, 32'(bus2.mem_stall), 32'd0);
        chk({tag, " c4 rdata"}, bus2.rsp_rdata,      exp_rd);
        chk({tag, " c4 err"},   32'(bus2.rsp_err),   32'(exp_err));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " c5 valid"}, 32'(bus2.rsp_valid), 32'd0);
        chk({tag, " c5 busy"},  32'(bus2.busy),      32'd0);
    endtask

    task automatic store0(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = addr;
        bus0.req_be = 4'hF; bus0.req_wdata = wd;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk({tag, " valid"}, 32'(bus0.rsp_valid), 32'd1);
        chk({tag, " err"},   32'(bus0.rsp_err),   32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
        bus2.req_be = '0; bus2.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
        bus0.req_be = '0; bus0.req_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst valid2", 32'(bus2.rsp_valid), 32'd0);
        chk("rst rdata2", bus2.rsp_rdata,      32'd0);
        chk("rst err2",   32'(bus2.rsp_err),   32'd0);
        chk("rst busy2",  32'(bus2.busy),      32'd0);
        chk("rst busy0",  32'(bus0.busy),      32'd0);
        chk("rst valid0", 32'(bus0.rsp_valid), 32'd0);
        rst = 1'b1;

        // Full-word store and load back
        access2("t1 st", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 32'h10);
        access2("t1 ld", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 32'h10);

        // Byte-lane merge
        access2("t2 pre", 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 32'h20);
        access2("t2 st",  1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, 32'h20);
        access2("t2 ld",  1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, 32'h20);

        // Error cases leave the array untouched
        access2("t3 mis st", 1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h22);
        access2("t3 oor ld", 1'b0, 32'h400, 4'hF, 32'h0, 32'h0, 1'b1, 32'h400);
        access2("t3 ld20",   1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, 32'h20);

        // Empty byte mask and highest legal word
        access2("be0 st",  1'b1, 32'h10, 4'h0, 32'h12345678, 32'h0, 1'b0, 32'h10);
        access2("be0 ld",  1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 32'h10);
        access2("top st",  1'b1, 32'h3FC, 4'hF, 32'h0F0F1234, 32'h0, 1'b0, 32'h3FC);
        access2("top ld",  1'b0, 32'h3FC, 4'hF, 32'h0, 32'h0F0F1234, 1'b0, 32'h3FC);

        // Zero wait states, request held across two loads
        store0("t4 st8", 32'h8, 32'hCAFEF00D);
        store0("t4 stC", 32'hC, 32'h0BADC0DE);
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h8; bus0.req_be = 4'hF;
        @(negedge clk);
        chk("t4 c0 stall", 32'(bus0.mem_stall), 32'd1);
        chk("t4 c0 valid", 32'(bus0.rsp_valid), 32'd0);
        @(posedge clk); #1;
        bus0.req_addr = 32'hC;
        @(negedge clk);
        chk("t4 c1 valid", 32'(bus0.rsp_valid), 32'd1);
        chk("t4 c1 stall", 32'(bus0.mem_stall), 32'd0);
        chk("t4 c1 rdata", bus0.rsp_rdata,      32'hCAFEF00D);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4 c2 valid", 32'(bus0.rsp_valid), 32'd0);
        chk("t4 c2 stall", 32'(bus0.mem_stall), 32'd1);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("t4 c3 valid", 32'(bus0.rsp_valid), 32'd1);
        chk("t4 c3 stall", 32'(bus0.mem_stall), 32'd0);
        chk("t4 c3 rdata", bus0.rsp_rdata,      32'h0BADC0DE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4 c4 valid", 32'(bus0.rsp_valid), 32'd0);
        chk("t4 c4 busy",  32'(bus0.busy),      32'd0);

        // Reset during WAIT aborts the store
        access2("t5 pre", 1'b1, 32'h30, 4'hF, 32'h5, 32'h0, 1'b0, 32'h30);
        @(posedge clk); #1;
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1; bus2.req_addr = 32'h30;
        bus2.req_be = 4'hF; bus2.req_wdata = 32'h99;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        chk("t5 in wait", 32'(bus2.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("t5 rst valid", 32'(bus2.rsp_valid), 32'd0);
        chk("t5 rst rdata", bus2.rsp_rdata,      32'd0);
        chk("t5 rst err",   32'(bus2.rsp_err),   32'd0);
        chk("t5 rst busy",  32'(bus2.busy),      32'd0);
        chk("t5 rst stall", 32'(bus2.mem_stall), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5 hold valid", 32'(bus2.rsp_valid), 32'd0);
        end
        rst = 1'b1;
        access2("t5 ld", 1'b0, 32'h30, 4'hF, 32'h0, 32'h5, 1'b0, 32'h30);

        // Address change after acceptance is ignored
        access2("t6 st40", 1'b1, 32'h40, 4'hF, 32'hA0A0A0A0, 32'h0, 1'b0, 32'h40);
        access2("t6 st44", 1'b1, 32'h44, 4'hF, 32'h44444444, 32'h0, 1'b0, 32'h44);
        access2("t6 ld",   1'b0, 32'h40, 4'hF, 32'h0, 32'hA0A0A0A0, 1'b0, 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
